// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and defaults for the step-counter scheduler
package count_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam logic STEP1 = 1'b0;
  localparam logic STEP2 = 1'b1;

  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/count_step_sched_rr_arb2.sv
// rtl/count_step_sched_rr_arb2.sv - two-way round-robin arbiter, purely combinational
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt_oh,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      // On a tie the requester that did not win last time goes first.
      winner = ~last_owner;
    end
    gnt_oh = (|req) ? (winner ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/count_step_sched.sv
// rtl/count_step_sched.sv - shares one external step counter between two requesters
module count_step_sched
  import count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            req_step2,
  input  logic [1:0][LEN_W-1:0] req_len,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  cnt_rst,
  output logic                  cnt_ctrl,
  input  logic [WIDTH-1:0]      count_in
);

  sched_state_t     state, state_n;
  logic [LEN_W-1:0] remaining;
  logic             step;
  logic             owner;
  logic             last_owner;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       arb_gnt;
  logic             winner;

  rr_arb2 u_arb (
    .req       (req),
    .last_owner(last_owner),
    .gnt_oh    (arb_gnt),
    .winner    (winner)
  );

  always_comb begin
    state_n  = state;
    gnt      = 2'b00;
    done     = 2'b00;
    busy     = (state != IDLE);
    cnt_rst  = 1'b1;
    cnt_ctrl = STEP1;
    result   = result_q;
    case (state)
      IDLE: begin
        gnt = arb_gnt;
        if (|req) begin
          state_n = (req_len[winner] != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        cnt_rst  = 1'b0;
        cnt_ctrl = step;
        if (remaining == LEN_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // Present the live count so result is valid alongside the done pulse.
        done    = owner ? 2'b10 : 2'b01;
        result  = count_in;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      step       <= STEP1;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      result_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (|req)) begin
        remaining  <= req_len[winner];
        step       <= req_step2[winner];
        owner      <= winner;
        last_owner <= winner;
      end
      if (state == RUN) begin
        remaining <= remaining - LEN_W'(1);
      end
      if (state == DONE) begin
        result_q <= count_in;
      end
    end
  end

endmodule

// File: tb/tb_count_step_sched.sv
// tb/tb_count_step_sched.sv - scoreboard bench for count_step_sched with a counter model
module tb_count_step_sched;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req;
  logic [1:0]      req_step2;
  logic [1:0][3:0] req_len;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [3:0]      result;
  logic            busy;
  logic            cnt_rst;
  logic            cnt_ctrl;
  logic [3:0]      count_in;

  typedef struct {
    int owner;
    int res;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  count_step_sched #(.WIDTH(4), .LEN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_step2(req_step2),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .busy     (busy),
    .cnt_rst  (cnt_rst),
    .cnt_ctrl (cnt_ctrl),
    .count_in (count_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural model of the external count_especial counter.
  always @(posedge clk) begin
    if (cnt_rst) count_in <= 4'd0;
    else         count_in <= count_in + (cnt_ctrl ? 4'd2 : 4'd1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises done.
  always @(negedge clk) begin
    if (gnt != 2'b00 && done != 2'b00) check("gnt_done_overlap", 1, 0);
    if (done != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_owner", int'(done), 1 << e.owner);
        check("result", int'(result), e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk); #1;
  endtask

  task automatic wait_gnt(output int g);
    g = -1;
    for (int i = 0; i < 30; i++) begin
      if (gnt != 2'b00) begin
        g = cyc;
        break;
      end
      @(negedge clk); #1;
    end
    if (g < 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic run_single(input int idx, input logic st, input int len, input int exp_res);
    int g;
    req_step2[idx] = st;
    req_len[idx]   = 4'(len);
    req[idx]       = 1'b1;
    #1;
    wait_gnt(g);
    check("gnt_onehot", int'(gnt), 1 << idx);
    exp_q.push_back('{idx, exp_res, g + len + 1});
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk); #1;
      if (k == 1) req[idx] = 1'b0;
      check("cnt_rst_wave", int'(cnt_rst), (k <= len) ? 0 : 1);
      check("cnt_ctrl_wave", int'(cnt_ctrl), (k <= len) ? int'(st) : 0);
    end
    drain();
  endtask

  initial begin
    int g, prev, n;
    bit stop;
    rst_n = 1'b0; req = 2'b00; req_step2 = 2'b00; req_len = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt_rst", int'(cnt_rst), 1);
    check("rst_cnt_ctrl", int'(cnt_ctrl), 0);
    check("rst_result", int'(result), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    run_single(0, 1'b0, 5, 5);
    run_single(0, 1'b0, 0, 0);
    run_single(1, 1'b1, 9, 2);

    // Both requesters held: grants must alternate 0,1,0,1 every len+2 cycles.
    req_len[0] = 4'd2; req_len[1] = 4'd2; req_step2 = 2'b00;
    req = 2'b11;
    #1;
    n = 0; prev = 0; stop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt != 2'b00) begin
        check("rr_order", int'(gnt), (n % 2 == 0) ? 1 : 2);
        if (n > 0) check("rr_spacing", cyc - prev, 4);
        exp_q.push_back('{int'(gnt[1]), 2, cyc + 3});
        prev = cyc;
        n++;
        if (n == 4) stop = 1'b1;
      end
      @(negedge clk); #1;
      if (stop) begin
        req = 2'b00;
        break;
      end
    end
    check("rr_grants", n, 4);
    drain();

    // Reset during RUN cycle 3 of a len=7 run.
    req_step2[0] = 1'b0; req_len[0] = 4'd7; req[0] = 1'b1;
    #1;
    wait_gnt(g);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 1) req[0] = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_cnt_rst", int'(cnt_rst), 1);
    check("abort_result", int'(result), 0);
    check("abort_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;

    // Field changes and a competing request during RUN must not disturb the run.
    req_step2[0] = 1'b0; req_len[0] = 4'd3; req[0] = 1'b1;
    #1;
    wait_gnt(g);
    check("chg_gnt0", int'(gnt), 1);
    exp_q.push_back('{0, 3, g + 4});
    @(negedge clk); #1;
    req[0] = 1'b0; req_len[0] = 4'd15;
    req_step2[1] = 1'b1; req_len[1] = 4'd1; req[1] = 1'b1;
    #1;
    wait_gnt(n);
    check("chg_gnt1", int'(gnt), 2);
    check("chg_gnt1_cycle", n, g + 5);
    exp_q.push_back('{1, 2, n + 2});
    @(negedge clk); #1;
    req[1] = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
